// File: rtl/qpu_exu_bjp_resolve_pkg.sv
// Shared branch/jump op encodings and the sequential PC increment for the BJP resolve unit.
package qpu_exu_bjp_resolve_pkg;

    typedef enum logic [2:0] {
        BJP_OP_BEQ  = 3'd0,
        BJP_OP_BNE  = 3'd1,
        BJP_OP_JAL  = 3'd2,
        BJP_OP_RSVD = 3'd3,
        BJP_OP_BLT  = 3'd4,
        BJP_OP_BGE  = 3'd5,
        BJP_OP_BLTU = 3'd6,
        BJP_OP_BGEU = 3'd7
    } bjp_op_e;

    localparam int BJP_SEQ_INCR = 4;

endpackage

// File: rtl/qpu_exu_bjp_resolve_cmp.sv
// Combinational branch condition evaluator: (op, rs1, rs2) -> taken.
module qpu_exu_bjp_cmp
    import qpu_exu_bjp_resolve_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (bjp_op_e'(op))
            BJP_OP_BEQ:  taken = (rs1 == rs2);
            BJP_OP_BNE:  taken = (rs1 != rs2);
            BJP_OP_JAL:  taken = 1'b1;
            BJP_OP_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            BJP_OP_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            BJP_OP_BLTU: taken = (rs1 <  rs2);
            BJP_OP_BGEU: taken = (rs1 >= rs2);
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/qpu_exu_bjp_resolve.sv
// Branch/jump resolution: commit pulse, held flush request with corrected PC.
// Optional performance counters enabled by defining QPU_BJP_PERF_CNT_EN.
module qpu_exu_bjp_resolve
    import qpu_exu_bjp_resolve_pkg::*;
#(
    parameter int PC_SIZE = 32,
    parameter int XLEN    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bjp_i_valid,
    output logic               bjp_i_ready,
    input  logic [PC_SIZE-1:0] bjp_i_pc,
    input  logic [XLEN-1:0]    bjp_i_imm,
    input  logic [XLEN-1:0]    bjp_i_rs1,
    input  logic [XLEN-1:0]    bjp_i_rs2,
    input  logic [2:0]         bjp_i_op,
    input  logic               bjp_i_prdt_taken,
    output logic               bjp_cmt_valid,
    output logic               bjp_cmt_mispred,
    output logic               flush_req,
    output logic [PC_SIZE-1:0] flush_pc,
    input  logic               flush_ack
`ifdef QPU_BJP_PERF_CNT_EN
    ,
    output logic [31:0]        bjp_cnt_total,
    output logic [31:0]        bjp_cnt_mispred
`endif
);

    logic               taken;
    logic               accept;
    logic               mispred;
    logic [PC_SIZE-1:0] target;

    qpu_exu_bjp_cmp #(.XLEN(XLEN)) u_cmp (
        .op    (bjp_i_op),
        .rs1   (bjp_i_rs1),
        .rs2   (bjp_i_rs2),
        .taken (taken)
    );

    // Wrong-path branches arriving while a flush is pending are simply not accepted.
    assign bjp_i_ready = ~flush_req;
    assign accept      = bjp_i_valid & bjp_i_ready;
    assign mispred     = taken ^ bjp_i_prdt_taken;
    assign target      = taken ? (bjp_i_pc + bjp_i_imm[PC_SIZE-1:0])
                               : (bjp_i_pc + PC_SIZE'(BJP_SEQ_INCR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bjp_cmt_valid   <= 1'b0;
            bjp_cmt_mispred <= 1'b0;
        end else begin
            bjp_cmt_valid   <= accept;
            bjp_cmt_mispred <= accept & mispred;
        end
    end

    // accept and a pending flush are mutually exclusive, so set/clear never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_req <= 1'b0;
            flush_pc  <= '0;
        end else if (accept && mispred) begin
            flush_req <= 1'b1;
            flush_pc  <= target;
        end else if (flush_req && flush_ack) begin
            flush_req <= 1'b0;
        end
    end

`ifdef QPU_BJP_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bjp_cnt_total   <= '0;
            bjp_cnt_mispred <= '0;
        end else if (accept) begin
            bjp_cnt_total <= bjp_cnt_total + 32'd1;
            if (mispred)
                bjp_cnt_mispred <= bjp_cnt_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_qpu_exu_bjp_resolve.sv
// Self-checking bench for qpu_exu_bjp_resolve: directed cases plus randomized traffic vs a reference model.
module tb_qpu_exu_bjp_resolve;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bjp_i_valid;
    logic        bjp_i_ready;
    logic [31:0] bjp_i_pc;
    logic [31:0] bjp_i_imm;
    logic [31:0] bjp_i_rs1;
    logic [31:0] bjp_i_rs2;
    logic [2:0]  bjp_i_op;
    logic        bjp_i_prdt_taken;
    logic        bjp_cmt_valid;
    logic        bjp_cmt_mispred;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic        flush_ack;
`ifdef QPU_BJP_PERF_CNT_EN
    logic [31:0] bjp_cnt_total;
    logic [31:0] bjp_cnt_mispred;
`endif

    always #5 clk = ~clk;

    qpu_exu_bjp_resolve #(.PC_SIZE(32), .XLEN(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bjp_i_valid      (bjp_i_valid),
        .bjp_i_ready      (bjp_i_ready),
        .bjp_i_pc         (bjp_i_pc),
        .bjp_i_imm        (bjp_i_imm),
        .bjp_i_rs1        (bjp_i_rs1),
        .bjp_i_rs2        (bjp_i_rs2),
        .bjp_i_op         (bjp_i_op),
        .bjp_i_prdt_taken (bjp_i_prdt_taken),
        .bjp_cmt_valid    (bjp_cmt_valid),
        .bjp_cmt_mispred  (bjp_cmt_mispred),
        .flush_req        (flush_req),
        .flush_pc         (flush_pc),
        .flush_ack        (flush_ack)
`ifdef QPU_BJP_PERF_CNT_EN
        ,
        .bjp_cnt_total    (bjp_cnt_total),
        .bjp_cnt_mispred  (bjp_cnt_mispred)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    bit          m_flush;
    logic [31:0] m_fpc;
    bit          m_cmt;
    bit          m_misp;
    logic [31:0] m_tot;
    logic [31:0] m_mcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return 1'b1;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return {32'd0, a} < {32'd0, b};
            3'd7:    return {32'd0, a} >= {32'd0, b};
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input bit v, input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] a, input logic [31:0] b, input bit prdt, input bit ack);
        bjp_i_valid      = v;
        bjp_i_op         = op;
        bjp_i_pc         = pc;
        bjp_i_imm        = imm;
        bjp_i_rs1        = a;
        bjp_i_rs2        = b;
        bjp_i_prdt_taken = prdt;
        flush_ack        = ack;
    endtask

    task automatic model_reset();
        m_flush = 0; m_fpc = '0; m_cmt = 0; m_misp = 0; m_tot = '0; m_mcnt = '0;
    endtask

    // Advance one clock: update model from the inputs currently driven, then compare after the edge.
    task automatic step(input string tag);
        bit          acc, tk;
        logic [31:0] tgt;
        chk({tag, ".ready_pre"}, {31'd0, bjp_i_ready}, {31'd0, !m_flush});
        acc = bjp_i_valid && !m_flush;
        tk  = ref_taken(bjp_i_op, bjp_i_rs1, bjp_i_rs2);
        tgt = tk ? bjp_i_pc + bjp_i_imm : bjp_i_pc + 32'd4;
        m_cmt  = acc;
        m_misp = acc && (tk != bjp_i_prdt_taken);
        if (acc) m_tot = m_tot + 1;
        if (m_misp) m_mcnt = m_mcnt + 1;
        if (m_flush && flush_ack) m_flush = 0;
        else if (m_misp) begin m_flush = 1; m_fpc = tgt; end
        @(posedge clk);
        #1;
        chk({tag, ".cmt_valid"}, {31'd0, bjp_cmt_valid}, {31'd0, m_cmt});
        if (m_cmt) chk({tag, ".mispred"}, {31'd0, bjp_cmt_mispred}, {31'd0, m_misp});
        chk({tag, ".flush_req"}, {31'd0, flush_req}, {31'd0, m_flush});
        chk({tag, ".flush_pc"}, flush_pc, m_fpc);
        chk({tag, ".ready"}, {31'd0, bjp_i_ready}, {31'd0, !m_flush});
`ifdef QPU_BJP_PERF_CNT_EN
        chk({tag, ".cnt_total"}, bjp_cnt_total, m_tot);
        chk({tag, ".cnt_mispred"}, bjp_cnt_mispred, m_mcnt);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0);
        model_reset();
        #12;
        chk("reset.cmt_valid", {31'd0, bjp_cmt_valid}, 32'd0);
        chk("reset.mispred", {31'd0, bjp_cmt_mispred}, 32'd0);
        chk("reset.flush_req", {31'd0, flush_req}, 32'd0);
        chk("reset.flush_pc", flush_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset.ready", {31'd0, bjp_i_ready}, 32'd1);

        // Case 1: BEQ taken predicted not-taken
        drive(1, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 0, 0);
        step("c1");
        chk("c1.flush_pc_const", flush_pc, 32'h120);
        drive(0, 3'd0, 32'h0, 32'h0, 32'd0, 32'd0, 0, 1);
        step("c1.ack");
        // Case 2: BNE not taken, predicted not taken
        drive(1, 3'd1, 32'h200, 32'h40, 32'd7, 32'd7, 0, 0);
        step("c2");
`ifdef QPU_BJP_PERF_CNT_EN
        chk("c2.total_const", bjp_cnt_total, 32'd2);
        chk("c2.mcnt_const", bjp_cnt_mispred, 32'd1);
`endif
        // Case 3: BLT signed taken vs BLTU not taken, opposite predictions
        drive(1, 3'd4, 32'h300, 32'h80, 32'hFFFF_FFFF, 32'd1, 0, 0);
        step("c3.blt");
        chk("c3.blt_pc_const", flush_pc, 32'h380);
        drive(0, 3'd0, 32'h0, 32'h0, 32'd0, 32'd0, 0, 1);
        step("c3.ack");
        drive(1, 3'd6, 32'h400, 32'h80, 32'hFFFF_FFFF, 32'd1, 1, 0);
        step("c3.bltu");
        chk("c3.bltu_pc_const", flush_pc, 32'h404);
        // Case 4: hold 3 cycles without ack, valid ignored, then ack
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'd2, 32'h500, 32'h10, 32'd0, 32'd0, 0, 0);
            step("c4.hold");
        end
        drive(1, 3'd2, 32'h500, 32'h10, 32'd0, 32'd0, 0, 1);
        step("c4.ack");
        // Case 5: wrap of pc+4
        drive(1, 3'd0, 32'hFFFF_FFFC, 32'h8, 32'd1, 32'd2, 1, 0);
        step("c5");
        chk("c5.wrap_const", flush_pc, 32'h0);
        // ack in the cycle flush_req first rises: flush still held one cycle
        drive(1, 3'd2, 32'h600, 32'h24, 32'd0, 32'd0, 0, 1);
        step("c5.ack");
        drive(1, 3'd2, 32'h700, 32'h4, 32'd0, 32'd0, 0, 1);
        step("early_ack.rise");
        drive(0, 3'd2, 32'h700, 32'h4, 32'd0, 32'd0, 0, 1);
        step("early_ack.release");
        // Back-to-back correct branches
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'd7, 32'h800 + 32'(i * 4), 32'h10, 32'(i), 32'd2, (i >= 2), 0);
            step("b2b");
        end
        // Case 6: reset while flushing
        drive(1, 3'd2, 32'h900, 32'h40, 32'd0, 32'd0, 0, 0);
        step("c6.set");
        drive(0, 3'd0, 32'h0, 32'h0, 32'd0, 32'd0, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("c6.async_clear", {31'd0, flush_req}, 32'd0);
        chk("c6.ready", {31'd0, bjp_i_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step("c6.after");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            if ($urandom_range(0, 3) == 0) b = a ^ 32'h8000_0000;
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 32'($urandom) & 32'hFFFF_FFFC,
                  32'($urandom), a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
